spi_reg_bank: RTL and testbench
===============================

// Module: spi_reg_bank
// PURPOSE
//  SPI register bank and POCI serializer, directly downstream of the PICO byte deserializer/address-pointer stage.
//  Stores data bytes into an 8-bit register array at the current address pointer and exposes the array to the chip.
//  On each byte boundary, loads the addressed register into a shifter and drives it MSB-first on poci.
//  Address 0 is reserved ("pointer not set"); register index = addr-1.
// PARAMETERS
//  NUM_REGS   16     number of addressable registers (addresses 1..NUM_REGS)
//  RO_BASE    13     first read-only address; addresses RO_BASE..NUM_REGS read ro_status, ignore writes
//  RESET_VAL  8'h00  reset value of every read/write register
// PORTS
//  sclk       in   1                        SPI clock; all state on posedge
//  rstn       in   1                        async active-low external reset (NOT the transaction-end reset)
//  byte_done  in   1                        1-cycle pulse: a full byte was just assembled upstream
//  wr_en      in   1                        qualifies byte_done as a data byte (0 = address byte)
//  addr       in   8                        current address pointer from upstream
//  wdata      in   8                        byte to write
//  ro_status  in   (NUM_REGS-RO_BASE+1)*8   read-only values; slice k = address RO_BASE+k
//  regs_flat  out  (RO_BASE-1)*8            R/W register contents; slice i = address i+1
//  poci       out  1                        serial read data, MSB first
//  wr_err     out  1                        sticky illegal-write flag
// BEHAVIOUR
//  Reset (rstn=0, async): R/W regs=RESET_VAL, shifter=0, bit_cnt=0, poci=0, wr_err=0.
//   Registers are reset by rstn only; they persist across transactions.
//  Write: posedge with byte_done & wr_en & 1<=addr<RO_BASE -> reg[addr-1]<=wdata.
//   Visible on regs_flat one cycle later.
//  Illegal write: byte_done & wr_en & (addr==0 | addr>=RO_BASE) -> no reg change.
//   wr_err<=1 (sticky until rstn). Writes to RO addresses are illegal even if addr<=NUM_REGS.
//  Read value rv(addr):
//   - 1..RO_BASE-1 -> reg value
//   - RO_BASE..NUM_REGS -> ro_status slice
//   - 0 or >NUM_REGS -> 8'h00
//  Shifter (8b) + bit_cnt (4b, 0..8):
//   - byte_done=1: shifter<=rv(addr); bit_cnt<=8. This applies to address and data bytes alike.
//   - else if bit_cnt!=0: shifter<={shifter[6:0],1'b0}; bit_cnt<=bit_cnt-1.
//   - else: hold (shifter is 0 after 8 shifts).
//  poci = shifter[7] (registered, combinationally taken from the flop). Latency: the MSB of rv appears on poci
//   the cycle after byte_done. The remaining bits follow on each subsequent posedge.
//  Same-cycle read/write at the same address: the shifter loads the OLD value (read-before-write).
//   The new value is seen on the next load.
//  byte_done arriving while bit_cnt!=0: the reload wins, the previous byte is truncated, and bit_cnt is reset to 8.
//  addr changes without byte_done are ignored; addr/wdata are sampled only on the byte_done cycle.
//  rstn asserted mid-shift: poci goes to 0 immediately (async); no partial write occurs.
//  Width rules: addr compared as unsigned 8b; index arithmetic addr-1 only evaluated when addr>=1.
//  Elaboration check: 1 < RO_BASE <= NUM_REGS+1, NUM_REGS <= 255.
// STRUCTURE
//  Package psec5_spi_pkg:
//   - localparam DATA_W=8 and ADDR_RSVD=8'h00
//   - typedef logic [7:0] spi_byte_t
//   - function is_rw_addr(addr, RO_BASE)
//  Sub-module poci_shifter: holds the shifter, bit_cnt and poci.
//   Ports: sclk, rstn, load, load_data[7:0], poci.
//  Top level: register array, read mux, wr_err.
// TESTING
//  T1 reset: rstn low with random inputs -> regs_flat all RESET_VAL, poci=0, wr_err=0; released -> all unchanged.
//  T2 write/readback:
//   - byte_done,wr_en,addr=3,wdata=A5 -> regs_flat[23:16]=A5 the next cycle.
//   - byte_done,wr_en=0,addr=3 -> poci bits 1,0,1,0,0,1,0,1 on the next 8 cycles, then 0.
//  T3 read-before-write: reg2=3C, then byte_done,wr_en,addr=2,wdata=C3.
//   -> poci shifts 3C; reg2=C3; the next load at addr 2 shifts C3.
//  T4 illegal writes: wr_en writes to addr 0, RO_BASE, and 8'hFF -> no regs_flat change, wr_err=1 and stays 1.
//   A subsequent legal write does not clear it.
//  T5 RO/out-of-range read: ro_status slice0=5A.
//   - load at RO_BASE -> poci 5A.
//   - load at NUM_REGS+1 -> poci all zeros.
//  T6 truncation/reset mid-op: byte_done again 3 cycles after a load of FF -> poci reloads the new byte MSB next cycle.
//   rstn pulse mid-shift -> poci=0 at once; regs reset to RESET_VAL.

Source files
------------

// File: rtl/psec5_spi_pkg.sv
// Shared types and helpers for the SPI register bank slice.
// Address 0 is the reserved "pointer not set" value.
package psec5_spi_pkg;

   localparam int unsigned DATA_W    = 8;
   localparam logic [7:0]  ADDR_RSVD = 8'h00;

   typedef logic [DATA_W-1:0] spi_byte_t;

   // True for addresses backed by a writable register (1..ro_base-1).
   function automatic logic is_rw_addr(input logic [7:0] addr, input int unsigned ro_base);
      return (addr != ADDR_RSVD) && ({24'h0, addr} < ro_base);
   endfunction

endpackage

// File: rtl/poci_shifter.sv
// POCI serializer: loads a byte on each byte boundary and shifts it out MSB first.
// A reload always wins over an in-progress shift.
module poci_shifter
   import psec5_spi_pkg::*;
(
   input  logic      sclk,
   input  logic      rstn,
   input  logic      load,
   input  spi_byte_t load_data,
   output logic      poci
);

   spi_byte_t  shift_q, shift_d;
   logic [3:0] bit_cnt_q, bit_cnt_d;

   always_comb begin
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      if (load) begin
         shift_d   = load_data;
         bit_cnt_d = 4'd8;
      end else if (bit_cnt_q != 4'd0) begin
         shift_d   = {shift_q[6:0], 1'b0};
         bit_cnt_d = bit_cnt_q - 4'd1;
      end
   end

   always_ff @(posedge sclk or negedge rstn) begin
      if (!rstn) begin
         shift_q   <= '0;
         bit_cnt_q <= 4'd0;
      end else begin
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
      end
   end

   assign poci = shift_q[7];

endmodule

// File: rtl/spi_reg_bank.sv
// SPI register bank: R/W register array, read mux over R/W and read-only space,
// sticky illegal-write flag, and the POCI serializer.
module spi_reg_bank
   import psec5_spi_pkg::*;
#(
   parameter int unsigned NUM_REGS  = 16,
   parameter int unsigned RO_BASE   = 13,
   parameter logic [7:0]  RESET_VAL = 8'h00
) (
   input  logic                              sclk,
   input  logic                              rstn,
   input  logic                              byte_done,
   input  logic                              wr_en,
   input  logic [7:0]                        addr,
   input  logic [7:0]                        wdata,
   input  logic [(NUM_REGS-RO_BASE+1)*8-1:0] ro_status,
   output logic [(RO_BASE-1)*8-1:0]          regs_flat,
   output logic                              poci,
   output logic                              wr_err
);

   localparam int unsigned NUM_RW = RO_BASE - 1;
   localparam int unsigned NUM_RO = NUM_REGS - RO_BASE + 1;

   if (!((RO_BASE > 1) && (RO_BASE <= NUM_REGS + 1) && (NUM_REGS <= 255))) begin : g_bad_params
      $error("spi_reg_bank: illegal NUM_REGS/RO_BASE combination");
   end

   spi_byte_t regs_q [NUM_RW];
   spi_byte_t regs_d [NUM_RW];
   logic      wr_err_q, wr_err_d;
   spi_byte_t rd_val;
   logic      wr_req;

   assign wr_req = byte_done & wr_en;

   // Address decode by comparison keeps addr-1 from ever being evaluated at addr 0.
   always_comb begin
      for (int unsigned i = 0; i < NUM_RW; i++) begin
         regs_d[i] = regs_q[i];
         if (wr_req && (addr == 8'(i + 1))) begin
            regs_d[i] = wdata;
         end
      end
      wr_err_d = wr_err_q | (wr_req & ~is_rw_addr(addr, RO_BASE));
   end

   // Read mux sees the pre-write value, giving read-before-write on same-cycle access.
   always_comb begin
      rd_val = '0;
      for (int unsigned i = 0; i < NUM_RW; i++) begin
         if (addr == 8'(i + 1)) begin
            rd_val = regs_q[i];
         end
      end
      for (int unsigned k = 0; k < NUM_RO; k++) begin
         if (addr == 8'(RO_BASE + k)) begin
            rd_val = ro_status[k*8 +: 8];
         end
      end
   end

   always_ff @(posedge sclk or negedge rstn) begin
      if (!rstn) begin
         for (int unsigned i = 0; i < NUM_RW; i++) begin
            regs_q[i] <= RESET_VAL;
         end
         wr_err_q <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < NUM_RW; i++) begin
            regs_q[i] <= regs_d[i];
         end
         wr_err_q <= wr_err_d;
      end
   end

   always_comb begin
      for (int unsigned i = 0; i < NUM_RW; i++) begin
         regs_flat[i*8 +: 8] = regs_q[i];
      end
   end

   assign wr_err = wr_err_q;

   poci_shifter u_poci_shifter (
      .sclk      (sclk),
      .rstn      (rstn),
      .load      (byte_done),
      .load_data (rd_val),
      .poci      (poci)
   );

endmodule

// File: tb/tb_spi_reg_bank.sv
// Self-checking bench for spi_reg_bank: a reference model predicts each loaded byte,
// whose bits are queued and compared against poci as they shift out.
module tb_spi_reg_bank;

   localparam int unsigned NUM_REGS = 16;
   localparam int unsigned RO_BASE  = 13;
   localparam int unsigned NUM_RW   = RO_BASE - 1;
   localparam logic [7:0]  RST_VAL  = 8'h00;

   logic        sclk      = 1'b0;
   logic        rstn      = 1'b0;
   logic        byte_done = 1'b0;
   logic        wr_en     = 1'b0;
   logic [7:0]  addr      = 8'h00;
   logic [7:0]  wdata     = 8'h00;
   logic [31:0] ro_status = 32'h7E3C_915A;
   logic [95:0] regs_flat;
   logic        poci;
   logic        wr_err;

   int unsigned vectors     = 0;
   int unsigned miscompares = 0;
   logic [7:0]  exp_regs [NUM_RW];
   logic        exp_err;
   logic        exp_q [$];

   spi_reg_bank #(
      .NUM_REGS  (NUM_REGS),
      .RO_BASE   (RO_BASE),
      .RESET_VAL (RST_VAL)
   ) dut (
      .sclk      (sclk),
      .rstn      (rstn),
      .byte_done (byte_done),
      .wr_en     (wr_en),
      .addr      (addr),
      .wdata     (wdata),
      .ro_status (ro_status),
      .regs_flat (regs_flat),
      .poci      (poci),
      .wr_err    (wr_err)
   );

   always #5 sclk = ~sclk;

   task automatic step();
      @(posedge sclk);
      #1;
   endtask

   function automatic logic [7:0] model_rv(input logic [7:0] a);
      if (a >= 8'd1 && a < 8'(RO_BASE)) return exp_regs[a - 8'd1];
      if (a >= 8'(RO_BASE) && a <= 8'(NUM_REGS)) return ro_status[(int'(a) - RO_BASE)*8 +: 8];
      return 8'h00;
   endfunction

   function automatic logic [95:0] model_flat();
      logic [95:0] f;
      for (int i = 0; i < NUM_RW; i++) f[i*8 +: 8] = exp_regs[i];
      return f;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NUM_RW; i++) exp_regs[i] = RST_VAL;
      exp_err = 1'b0;
      exp_q.delete();
   endtask

   // Drive one byte boundary; the expected shifter contents replace any pending bits.
   task automatic do_load(input logic [7:0] a, input logic we, input logic [7:0] d);
      logic [7:0] rv;
      rv = model_rv(a);
      exp_q.delete();
      for (int i = 7; i >= 0; i--) exp_q.push_back(rv[i]);
      if (we) begin
         if (a != 8'h00 && a < 8'(RO_BASE)) exp_regs[a - 8'd1] = d;
         else exp_err = 1'b1;
      end
      byte_done = 1'b1;
      wr_en     = we;
      addr      = a;
      wdata     = d;
      step();
      byte_done = 1'b0;
      wr_en     = 1'b0;
      addr      = 8'($urandom);
      wdata     = 8'($urandom);
   endtask

   task automatic drain(input string name);
      logic e;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         vectors++;
         if (poci !== e) begin
            miscompares++;
            $display("FAIL %s: poci=%b expected %b", name, poci, e);
         end
         step();
      end
      vectors++;
      if (poci !== 1'b0) begin
         miscompares++;
         $display("FAIL %s_idle: poci=%b expected 0", name, poci);
      end
   endtask

   task automatic test_reset();
      model_reset();
      rstn = 1'b0;
      for (int i = 0; i < 4; i++) begin
         byte_done = 1'($urandom);
         wr_en     = 1'($urandom);
         addr      = 8'($urandom_range(1, 12));
         wdata     = 8'($urandom);
         step();
      end
      vectors += 3;
      if (regs_flat !== model_flat()) begin
         miscompares++;
         $display("FAIL reset_regs: regs_flat=%h expected %h", regs_flat, model_flat());
      end
      if (poci !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_poci: poci=%b expected 0", poci);
      end
      if (wr_err !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_wr_err: wr_err=%b expected 0", wr_err);
      end
      byte_done = 1'b0;
      wr_en     = 1'b0;
      #3 rstn = 1'b1;
      step();
      vectors += 3;
      if (regs_flat !== model_flat()) begin
         miscompares++;
         $display("FAIL release_regs: regs_flat=%h expected %h", regs_flat, model_flat());
      end
      if (poci !== 1'b0) begin
         miscompares++;
         $display("FAIL release_poci: poci=%b expected 0", poci);
      end
      if (wr_err !== 1'b0) begin
         miscompares++;
         $display("FAIL release_wr_err: wr_err=%b expected 0", wr_err);
      end
   endtask

   task automatic test_write_readback();
      do_load(8'd3, 1'b1, 8'hA5);
      vectors += 2;
      if (regs_flat[23:16] !== 8'hA5) begin
         miscompares++;
         $display("FAIL wr_reg3: got %h expected a5", regs_flat[23:16]);
      end
      if (regs_flat !== model_flat()) begin
         miscompares++;
         $display("FAIL wr_flat: regs_flat=%h expected %h", regs_flat, model_flat());
      end
      drain("wr_old_shift");
      do_load(8'd3, 1'b0, 8'h00);
      drain("rd_reg3");
   endtask

   task automatic test_read_before_write();
      do_load(8'd2, 1'b1, 8'h3C);
      drain("rbw_first");
      do_load(8'd2, 1'b1, 8'hC3);
      vectors++;
      if (regs_flat[15:8] !== 8'hC3) begin
         miscompares++;
         $display("FAIL rbw_reg2: got %h expected c3", regs_flat[15:8]);
      end
      drain("rbw_old_value");
      do_load(8'd2, 1'b0, 8'h00);
      drain("rbw_new_value");
   endtask

   task automatic test_illegal_writes();
      logic [7:0] bad [3];
      bad[0] = 8'h00;
      bad[1] = 8'(RO_BASE);
      bad[2] = 8'hFF;
      for (int i = 0; i < 3; i++) begin
         do_load(bad[i], 1'b1, 8'h11 + 8'(i));
         vectors += 2;
         if (wr_err !== exp_err) begin
            miscompares++;
            $display("FAIL illegal_err_%0d: wr_err=%b expected %b", i, wr_err, exp_err);
         end
         if (regs_flat !== model_flat()) begin
            miscompares++;
            $display("FAIL illegal_regs_%0d: regs_flat=%h expected %h", i, regs_flat, model_flat());
         end
         drain("illegal_shift");
      end
      do_load(8'd5, 1'b1, 8'h66);
      vectors += 2;
      if (wr_err !== 1'b1) begin
         miscompares++;
         $display("FAIL sticky_err: wr_err=%b expected 1", wr_err);
      end
      if (regs_flat[39:32] !== 8'h66) begin
         miscompares++;
         $display("FAIL legal_after_err: got %h expected 66", regs_flat[39:32]);
      end
      drain("legal_after_err_shift");
   endtask

   task automatic test_ro_read();
      do_load(8'(RO_BASE), 1'b0, 8'h00);
      drain("ro_slice0");
      do_load(8'(NUM_REGS + 1), 1'b0, 8'h00);
      drain("out_of_range");
      do_load(8'(NUM_REGS), 1'b0, 8'h00);
      drain("ro_last");
      do_load(8'h00, 1'b0, 8'h00);
      drain("addr_zero");
   endtask

   task automatic test_truncate_reset();
      logic e;
      do_load(8'd4, 1'b1, 8'hFF);
      drain("trunc_setup");
      do_load(8'd4, 1'b0, 8'h00);
      for (int i = 0; i < 3; i++) begin
         e = exp_q.pop_front();
         vectors++;
         if (poci !== e) begin
            miscompares++;
            $display("FAIL trunc_pre_%0d: poci=%b expected %b", i, poci, e);
         end
         step();
      end
      do_load(8'd3, 1'b0, 8'h00);
      drain("trunc_reload");
      do_load(8'd4, 1'b0, 8'h00);
      for (int i = 0; i < 2; i++) begin
         e = exp_q.pop_front();
         vectors++;
         if (poci !== e) begin
            miscompares++;
            $display("FAIL rst_pre_%0d: poci=%b expected %b", i, poci, e);
         end
         step();
      end
      #2 rstn = 1'b0;
      model_reset();
      #1;
      vectors += 3;
      if (poci !== 1'b0) begin
         miscompares++;
         $display("FAIL async_rst_poci: poci=%b expected 0", poci);
      end
      if (regs_flat !== model_flat()) begin
         miscompares++;
         $display("FAIL async_rst_regs: regs_flat=%h expected %h", regs_flat, model_flat());
      end
      if (wr_err !== 1'b0) begin
         miscompares++;
         $display("FAIL async_rst_err: wr_err=%b expected 0", wr_err);
      end
      #2 rstn = 1'b1;
      step();
      vectors++;
      if (poci !== 1'b0) begin
         miscompares++;
         $display("FAIL post_rst_poci: poci=%b expected 0", poci);
      end
      do_load(8'd4, 1'b0, 8'h00);
      drain("post_rst_read");
   endtask

   initial begin
      test_reset();
      test_write_readback();
      test_read_before_write();
      test_illegal_writes();
      test_ro_read();
      test_truncate_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
